// File: rtl/logic_response_analyzer_pkg.sv
// Shared definitions for the logic-unit response analyzer.
//   DEF_*    : default widths, MISR feedback polynomial and seed
//   state_e  : 2-bit FSM state encoding
package logic_response_analyzer_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_COUNT_WIDTH = 16;
    localparam logic [31:0] DEF_MISR_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_MISR_SEED   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_COMPARE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

endpackage

// File: rtl/logic_response_analyzer_misr_32.sv
// Registered multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset (resets to SEED)
//   load       : load SEED (takes priority over step)
//   step       : shift with polynomial feedback and fold in y
//   y          : input word
//   sig        : current signature
module misr_32
    import logic_response_analyzer_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   POLY       = DEF_MISR_POLY,
    parameter logic [DATA_WIDTH-1:0]   SEED       = DEF_MISR_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] sig
);

    logic [DATA_WIDTH-1:0] sig_q;
    logic [DATA_WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (step) begin
            // Polynomial feedback applies when the MSB shifts out.
            sig_d = {sig_q[DATA_WIDTH-2:0], 1'b0}
                  ^ (sig_q[DATA_WIDTH-1] ? POLY : '0)
                  ^ y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/logic_response_analyzer.sv
// Compacts a stream of logic-unit result words into a MISR signature and
// compares it against a golden value, giving a PASS/FAIL verdict.
//   CLK, RST    : clock, asynchronous active-low reset
//   START       : begin a run (honoured only in IDLE or DONE)
//   NUM_SAMPLES : words per run, latched on START
//   GOLDEN      : expected signature, latched on START
//   VALID, Y    : result word handshake input
//   READY       : analyzer accepts Y this cycle (registered)
//   BUSY        : run in progress (COLLECT or COMPARE)
//   DONE, PASS  : verdict valid / signature matched, held until next START
//   SIGNATURE   : current MISR contents
//   SAMPLE_CNT  : words accepted in the current run
module logic_response_analyzer
    import logic_response_analyzer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned           COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter logic [DATA_WIDTH-1:0] MISR_POLY   = DEF_MISR_POLY,
    parameter logic [DATA_WIDTH-1:0] MISR_SEED   = DEF_MISR_SEED
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [COUNT_WIDTH-1:0] NUM_SAMPLES,
    input  logic [DATA_WIDTH-1:0]  GOLDEN,
    input  logic                   VALID,
    input  logic [DATA_WIDTH-1:0]  Y,
    output logic                   READY,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   PASS,
    output logic [DATA_WIDTH-1:0]  SIGNATURE,
    output logic [COUNT_WIDTH-1:0] SAMPLE_CNT
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] num_q, num_d;
    logic [DATA_WIDTH-1:0]  golden_q, golden_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   misr_load;
    logic                   misr_step;
    logic [DATA_WIDTH-1:0]  misr_sig;

    misr_32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .POLY       (MISR_POLY),
        .SEED       (MISR_SEED)
    ) u_misr (
        .clk   (CLK),
        .rst_n (RST),
        .load  (misr_load),
        .step  (misr_step),
        .y     (Y),
        .sig   (misr_sig)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        golden_d  = golden_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_step = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    num_d     = NUM_SAMPLES;
                    golden_d  = GOLDEN;
                    pass_d    = 1'b0;
                    state_d   = (NUM_SAMPLES == '0) ? ST_COMPARE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (VALID && ready_q) begin
                    misr_step = 1'b1;
                    cnt_d     = cnt_q + COUNT_WIDTH'(1);
                    if (cnt_d == num_q) begin
                        state_d = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                pass_d  = (misr_sig == golden_q);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered flags
        // line up with the state they describe, without a cycle of lag.
        ready_d = (state_d == ST_COLLECT);
        busy_d  = (state_d == ST_COLLECT) || (state_d == ST_COMPARE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            golden_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            golden_q <= golden_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign READY      = ready_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign SIGNATURE  = misr_sig;
    assign SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_logic_response_analyzer.sv
// Directed and randomized checks of the response analyzer against a
// behavioural signature model.
module tb_logic_response_analyzer;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [15:0] NUM_SAMPLES = '0;
    logic [31:0] GOLDEN = '0;
    logic        VALID = 1'b0;
    logic [31:0] Y = '0;
    logic        READY, BUSY, DONE, PASS;
    logic [31:0] SIGNATURE;
    logic [15:0] SAMPLE_CNT;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] words[$];

    always #5 CLK = ~CLK;

    logic_response_analyzer dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .NUM_SAMPLES (NUM_SAMPLES),
        .GOLDEN      (GOLDEN),
        .VALID       (VALID),
        .Y           (Y),
        .READY       (READY),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PASS        (PASS),
        .SIGNATURE   (SIGNATURE),
        .SAMPLE_CNT  (SAMPLE_CNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Signature of the word list: shift left, fold feedback when the MSB
    // falls off, then xor the word in.
    function automatic logic [31:0] ref_sig();
        logic [31:0] s;
        logic        msb;
        s = SEED;
        foreach (words[i]) begin
            msb = s[31];
            s   = (s << 1) ^ words[i];
            if (msb) s = s ^ POLY;
        end
        return s;
    endfunction

    task automatic chk_idle_reset(input string tag);
        chk({tag, "/ready"}, 32'(READY), 0);
        chk({tag, "/busy"},  32'(BUSY), 0);
        chk({tag, "/done"},  32'(DONE), 0);
        chk({tag, "/pass"},  32'(PASS), 0);
        chk({tag, "/sig"},   SIGNATURE, SEED);
        chk({tag, "/cnt"},   32'(SAMPLE_CNT), 0);
    endtask

    // Complete run from IDLE/DONE using the current contents of words.
    task automatic do_run(input logic [31:0] golden, input bit gapped, input string tag);
        logic [31:0] exp_sig;
        int          n;
        n       = words.size();
        exp_sig = ref_sig();
        START = 1'b1; NUM_SAMPLES = 16'(n); GOLDEN = golden; VALID = 1'b0;
        tick();
        START = 1'b0; NUM_SAMPLES = 16'($urandom); GOLDEN = $urandom;
        chk({tag, "/start_done"}, 32'(DONE), 0);
        chk({tag, "/start_busy"}, 32'(BUSY), 1);
        chk({tag, "/start_sig"},  SIGNATURE, SEED);
        chk({tag, "/start_cnt"},  32'(SAMPLE_CNT), 0);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                repeat ($urandom_range(0, 2)) begin
                    VALID = 1'b0; Y = $urandom;
                    tick();
                    chk({tag, "/gap_cnt"}, 32'(SAMPLE_CNT), 32'(i));
                end
            end
            chk({tag, "/ready"}, 32'(READY), 1);
            VALID = 1'b1; Y = words[i];
            tick();
            VALID = 1'b0;
            chk({tag, "/cnt"}, 32'(SAMPLE_CNT), 32'(i + 1));
        end
        // COMPARE cycle: a word offered now must be dropped.
        chk({tag, "/cmp_ready"}, 32'(READY), 0);
        chk({tag, "/cmp_done"},  32'(DONE), 0);
        chk({tag, "/cmp_busy"},  32'(BUSY), 1);
        VALID = 1'b1; Y = $urandom;
        tick();
        chk({tag, "/done"},  32'(DONE), 1);
        chk({tag, "/busy"},  32'(BUSY), 0);
        chk({tag, "/pass"},  32'(PASS), 32'(exp_sig == golden));
        chk({tag, "/sig"},   SIGNATURE, exp_sig);
        tick();
        VALID = 1'b0;
        chk({tag, "/hold_sig"},  SIGNATURE, exp_sig);
        chk({tag, "/hold_done"}, 32'(DONE), 1);
        chk({tag, "/hold_pass"}, 32'(PASS), 32'(exp_sig == golden));
    endtask

    initial begin
        logic [31:0] g;
        // Reset state
        tick(); tick();
        chk_idle_reset("por");
        RST = 1'b1;
        tick();
        chk_idle_reset("idle");

        // Single zero word: matching and mismatching golden
        words = {32'h0000_0000};
        do_run(32'hFB3E_E249, 1'b0, "single");
        chk("single/const_sig", SIGNATURE, 32'hFB3E_E249);
        chk("single/const_pass", 32'(PASS), 1);
        do_run(32'hFB3E_E248, 1'b0, "mismatch");
        chk("mismatch/const_pass", 32'(PASS), 0);
        chk("mismatch/const_sig", SIGNATURE, 32'hFB3E_E249);

        // Zero-length run: no READY cycle, seed compared directly
        words = {};
        do_run(32'hFFFF_FFFF, 1'b0, "zero");
        chk("zero/const_pass", 32'(PASS), 1);

        // Gapped AND/OR-style stream
        words = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        do_run(ref_sig(), 1'b1, "gapped");

        // Randomized runs, roughly half with a corrupted golden
        for (int r = 0; r < 8; r++) begin
            words = {};
            repeat ($urandom_range(1, 8)) words.push_back($urandom);
            g = ref_sig();
            if ($urandom_range(0, 1) == 1) g = g ^ (32'h1 << $urandom_range(0, 31));
            do_run(g, $urandom_range(0, 1) == 1, "rand");
        end

        // START during COLLECT is ignored
        words = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        g = ref_sig();
        START = 1'b1; NUM_SAMPLES = 16'd4; GOLDEN = g;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                START = 1'b1; NUM_SAMPLES = 16'd1; GOLDEN = 32'h0;
                tick();
                START = 1'b0;
                chk("ign/cnt", 32'(SAMPLE_CNT), 2);
                chk("ign/ready", 32'(READY), 1);
            end
            VALID = 1'b1; Y = words[i];
            tick();
            VALID = 1'b0;
            chk("ign/step_cnt", 32'(SAMPLE_CNT), 32'(i + 1));
        end
        tick();
        chk("ign/done", 32'(DONE), 1);
        chk("ign/pass", 32'(PASS), 1);
        chk("ign/sig", SIGNATURE, g);

        // START from DONE restarts
        START = 1'b1; NUM_SAMPLES = 16'd4; GOLDEN = g;
        tick();
        START = 1'b0;
        chk("restart/done", 32'(DONE), 0);
        chk("restart/pass", 32'(PASS), 0);
        chk("restart/sig", SIGNATURE, SEED);
        chk("restart/cnt", 32'(SAMPLE_CNT), 0);

        // Reset mid-run aborts to reset values
        for (int i = 0; i < 2; i++) begin
            VALID = 1'b1; Y = $urandom;
            tick();
        end
        VALID = 1'b0;
        chk("abort/pre_cnt", 32'(SAMPLE_CNT), 2);
        #2 RST = 1'b0;
        #1;
        chk_idle_reset("abort");
        tick();
        #2 RST = 1'b1;
        tick();
        chk_idle_reset("abort_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
